keypad_port: RTL
================

Name: keypad_port

Overview:
- Read-side bus responder: the CPU reads button state and press/release events from it over the shared 16-bit data bus.
- Synchronises and debounces N_BUTTONS push-buttons and queues edge events in a small FIFO.
- Decoded by the board on its own address-nibble chip select, alongside the write-only LED peripherals.
- Optional interrupt output.

Parameters:
- N_BUTTONS, 4: number of button inputs, 1..8.
- DEBOUNCE_CYCLES, 1000: consecutive stable clk cycles required to accept a new level, ≥2.
- FIFO_DEPTH, 8: event queue entries; power of 2, 2..16.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- data_bus  inout  16  driven only while enable&read, else high-Z.
- address_bus  input  2  register select (board passes address_bus[1:0]).
- enable  input  1  chip select.
- read  input  1  bus read strobe.
- write  input  1  bus write strobe.
- buttons  input  N_BUTTONS  raw, asynchronous, active-high.
- irq  output  1  level interrupt request.

Behaviour:
- Reset (reset=0, async): sync/debounce state, debounced levels, FIFO, overflow and CONTROL all cleared to 0. irq=0. data_bus high-Z.
- Input path: 2-FF synchroniser per button, then a debouncer. The debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any cycle of agreement resets the counter.
- Latency: raw edge to level change = 2 + DEBOUNCE_CYCLES cycles. The event is pushed 1 cycle later if no other event is pending ahead of it.
- Events:
  - A 0→1 debounced flip sets pending_press[i].
  - A 1→0 flip sets pending_release[i], but only if CONTROL[0]=1.
  - Arbiter pushes at most one event per cycle. Priority is lowest index, and press before release for the same index. The pushed pending bit is cleared.
- Event word: [8]=1 valid; [7]=1 press / 0 release; [2:0]=index; all other bits 0.
- FIFO full on push: the event is dropped, its pending bit is still cleared, and STATUS overflow is set (sticky).
- Simultaneous push and pop on a full FIFO is allowed, so the event is not dropped.
- Register map (address_bus):
  - 0 STATUS, read: [15] overflow, [14] empty, [12:8] count, [N_BUTTONS-1:0] debounced levels, other bits 0. Any write to STATUS clears overflow.
  - 1 EVENT, read: FIFO head, or 16'h0000 when empty. Writes ignored.
  - 2 CONTROL, read/write: [0] release_en, [1] irq_mask. Other bits read 0.
  - 3: reads 16'h0000; writes ignored.
- Read data is combinational from current state while enable&read is high.
- Pop rule: exactly one pop per read transaction. Pop happens on the cycle after enable&read falls, if that transaction addressed EVENT (address latched while the strobe is high) and the FIFO was non-empty. A strobe held for multiple cycles still pops once.
- Writes take effect on the posedge where enable&write is high. Writes repeated over multi-cycle strobes are idempotent.
- reset asserted mid-transaction: immediate clear; the pending pop is abandoned.

Optional Feature:
- KEYPAD_IRQ_EN defined: irq is registered and equals (count≠0 || overflow) && CONTROL[1]. It updates 1 cycle after the cause changes.
- KEYPAD_IRQ_EN undefined: irq is tied to 0. CONTROL[1] remains readable/writable storage with no effect.

Decomposition:
- Shared package: register address constants (KEYPAD_STATUS=0, KEYPAD_EVENT=1, KEYPAD_CONTROL=2), STATUS/CONTROL bit positions, event-word field positions.
- Sub-module button_debouncer: one synchroniser plus counter per button, with outputs level, rise and fall. Instantiated N_BUTTONS times.
- FIFO and arbiter stay inline.

Test Plan:
1. Reset, then read STATUS → 16'h4000 (empty). Read EVENT → 16'h0000. irq=0.
2. Button 2 bounces 1-0-1 for fewer than DEBOUNCE_CYCLES, then holds 1 → exactly one EVENT read of 16'h0182. STATUS[2]=1. A second EVENT read → 16'h0000.
3. CONTROL=16'h0001; press then release button 0 → EVENT reads 16'h0180 then 16'h0100. With CONTROL=0, the release queues nothing.
4. Buttons 3 and 1 go debounced-high in the same cycle → EVENT reads 16'h0181 then 16'h0183.
5. Queue FIFO_DEPTH+2 presses without reading → STATUS[15]=1, count=8. The 8 oldest events are kept. Writing STATUS clears [15]; count is unchanged.
6. A 5-cycle read strobe on EVENT with 2 entries queued → the first entry is stable for all 5 cycles, one pop, count 2→1. With KEYPAD_IRQ_EN and CONTROL=16'h0002, irq stays 1 until the last pop, then falls 1 cycle later.

Source files
------------

// File: rtl/keypad_port_pkg.sv
// rtl/keypad_port_pkg.sv - register map, bit positions and event-word helper for keypad_port
package keypad_port_pkg;

  // register select values on address_bus
  localparam logic [1:0] KEYPAD_STATUS  = 2'd0;
  localparam logic [1:0] KEYPAD_EVENT   = 2'd1;
  localparam logic [1:0] KEYPAD_CONTROL = 2'd2;

  // STATUS fields
  localparam int STATUS_OVF_BIT   = 15;
  localparam int STATUS_EMPTY_BIT = 14;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 5;

  // CONTROL fields
  localparam int CTRL_RELEASE_EN_BIT = 0;
  localparam int CTRL_IRQ_MASK_BIT   = 1;

  // EVENT word fields
  localparam int EVT_VALID_BIT = 8;
  localparam int EVT_PRESS_BIT = 7;
  localparam int EVT_INDEX_LSB = 0;
  localparam int EVT_INDEX_W   = 3;

  // compact FIFO entry; the full bus word is rebuilt on read
  typedef struct packed {
    logic                   press;
    logic [EVT_INDEX_W-1:0] index;
  } kp_event_t;

  function automatic logic [15:0] event_word(input kp_event_t ev);
    logic [15:0] w;
    w                                  = '0;
    w[EVT_VALID_BIT]                   = 1'b1;
    w[EVT_PRESS_BIT]                   = ev.press;
    w[EVT_INDEX_LSB +: EVT_INDEX_W]    = ev.index;
    return w;
  endfunction

endpackage

// File: rtl/keypad_port_button_debouncer.sv
// rtl/keypad_port_button_debouncer.sv - 2-FF synchroniser plus stability counter for one button
module keypad_port_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  // the level flips on the edge that completes DEBOUNCE_CYCLES of disagreement;
  // rise/fall pulse in that same cycle so the caller can latch them alongside
  assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise = flip & ~level;
  assign fall = flip & level;

  // bring the raw asynchronous input into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // count consecutive disagreeing cycles; any agreement restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (flip) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_port.sv
// rtl/keypad_port.sv - debounced keypad bus responder with event FIFO; irq enabled by KEYPAD_IRQ_EN
module keypad_port
  import keypad_port_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire  [15:0]          data_bus,
  input  logic [1:0]           address_bus,
  input  logic                 enable,
  input  logic                 read,
  input  logic                 write,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic                 irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [N_BUTTONS-1:0] level_v;
  logic [N_BUTTONS-1:0] rise_v;
  logic [N_BUTTONS-1:0] fall_v;
  logic [N_BUTTONS-1:0] pending_press;
  logic [N_BUTTONS-1:0] pending_release;
  logic [N_BUTTONS-1:0] clr_press;
  logic [N_BUTTONS-1:0] clr_release;
  logic                 push;
  logic                 push_ok;
  logic                 pop;
  logic                 drop;
  logic                 full;
  logic                 empty;
  kp_event_t            push_ev;
  kp_event_t            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic [1:0]           control;
  logic                 rd_strobe;
  logic                 wr_strobe;
  logic                 rd_active_q;
  logic                 rd_done;
  logic [1:0]           rd_addr_q;
  logic [15:0]          rdata;
  logic                 unused_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
      keypad_port_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .button(buttons[gi]),
        .level (level_v[gi]),
        .rise  (rise_v[gi]),
        .fall  (fall_v[gi])
      );
    end
  endgenerate

  assign rd_strobe   = enable & read;
  assign wr_strobe   = enable & write;
  assign rd_done     = rd_active_q & ~rd_strobe;
  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign pop         = rd_done && (rd_addr_q == KEYPAD_EVENT) && !empty;
  assign push_ok     = push && (!full || pop);
  assign drop        = push && !push_ok;
  assign unused_data = ^data_bus[15:2];

  // pick one pending event: lowest index first, press ahead of release
  always_comb begin
    push        = 1'b0;
    push_ev     = '0;
    clr_press   = '0;
    clr_release = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (!push) begin
        if (pending_press[i]) begin
          push          = 1'b1;
          push_ev.press = 1'b1;
          push_ev.index = 3'(i);
          clr_press[i]  = 1'b1;
        end else if (pending_release[i]) begin
          push           = 1'b1;
          push_ev.press  = 1'b0;
          push_ev.index  = 3'(i);
          clr_release[i] = 1'b1;
        end
      end
    end
  end

  // pending bits collect debounced edges and drop out when arbitrated, pushed or not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_press   <= '0;
      pending_release <= '0;
    end else begin
      pending_press   <= (pending_press & ~clr_press) | rise_v;
      pending_release <= (pending_release & ~clr_release)
                       | (fall_v & {N_BUTTONS{control[CTRL_RELEASE_EN_BIT]}});
    end
  end

  // remember the last address of a read strobe so the pop fires once it ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_active_q <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      rd_active_q <= rd_strobe;
      if (rd_strobe) rd_addr_q <= address_bus;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while count is zero so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_ev;
  end

  // sticky overflow and CONTROL register; a fresh drop wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      control  <= '0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (wr_strobe && address_bus == KEYPAD_STATUS)
        overflow <= 1'b0;
      if (wr_strobe && address_bus == KEYPAD_CONTROL)
        control <= data_bus[1:0];
    end
  end

  // read data straight from current state
  always_comb begin
    rdata = '0;
    case (address_bus)
      KEYPAD_STATUS: begin
        rdata[STATUS_OVF_BIT]                         = overflow;
        rdata[STATUS_EMPTY_BIT]                       = empty;
        rdata[STATUS_COUNT_LSB +: STATUS_COUNT_W]     = STATUS_COUNT_W'(count);
        rdata[N_BUTTONS-1:0]                          = level_v;
      end
      KEYPAD_EVENT: begin
        if (!empty) rdata = event_word(fifo_mem[rd_ptr]);
      end
      KEYPAD_CONTROL: begin
        rdata[1:0] = control;
      end
      default: rdata = '0;
    endcase
  end

  assign data_bus = (reset && rd_strobe) ? rdata : 16'bz;

`ifdef KEYPAD_IRQ_EN
  // level interrupt while events are queued or overflow is flagged, gated by the mask
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (!empty || overflow) && control[CTRL_IRQ_MASK_BIT];
  end
`else
  assign irq = 1'b0;
`endif

endmodule
